// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM/WB slice: widths, MEM handshake states
// and the MEM/WB register bundle.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              RegWrite;
        logic              MemtoReg;
        logic [DATA_W-1:0] ALU;
        logic [DATA_W-1:0] MEM;
        logic [REG_W-1:0]  rd;
    } mem_wb_t;

    function automatic logic is_misaligned(input logic [1:0] byte_lsb);
        return byte_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dm_handshake_fsm.sv
// Data-memory req/ack sequencer: state register, registered request fields,
// upstream stall. Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses.
module dm_handshake_fsm
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dm_ack,
`ifdef MEM_MISALIGN_TRAP_EN
    input  logic              misalign,
    output logic              trap_pulse,
`endif
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              stall,
    output logic              load_en,
    output mem_state_t        state_dbg
);

    mem_state_t state_q, state_d;
    logic       issue;
    logic       trap;
    logic       trap_chk;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_chk = misalign;
`else
    assign trap_chk = 1'b0;
`endif

    // Handshake: dm_req stays high with we/addr/wdata frozen from the issue edge
    // until the edge that samples the single-cycle dm_ack; dm_ack outside ACCESS is ignored.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        issue   = 1'b0;
        load_en = 1'b0;
        trap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!acc) begin
                    load_en = 1'b1;
                end else if (trap_chk) begin
                    trap = 1'b1;
                end else begin
                    issue   = 1'b1;
                    stall   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dm_ack) begin
                    load_en = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                dm_req   <= 1'b1;
                dm_we    <= is_store;
                dm_addr  <= addr;
                dm_wdata <= wdata;
            end else if (state_q == ACCESS && dm_ack) begin
                dm_req <= 1'b0;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_pulse <= 1'b0;
        else        trap_pulse <= trap;
    end
`else
    logic unused_trap;
    assign unused_trap = trap;
`endif

    assign state_dbg = state_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: data-memory access over req/ack with pipeline
// stall. Define MEM_MISALIGN_TRAP_EN to trap misaligned lw/sw (adds misalign_o).
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              stall_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALU_o,
    output logic [DATA_W-1:0] MEM_o,
    output logic [REG_W-1:0]  rd_o
);

    import pipe_pkg::*;

    // The bundle type is sized by pipe_pkg; keep these parameters at the package values.
    mem_wb_t    wb_q;
    mem_state_t state_dbg;
    logic       acc;
    logic       is_load;
    logic       load_en;

    assign acc     = MemRead_i | MemWrite_i;
    // A store wins when both MemRead_i and MemWrite_i are set.
    assign is_load = MemRead_i & ~MemWrite_i;

    dm_handshake_fsm #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc       (acc),
        .is_store  (MemWrite_i),
        .addr      (ALU_i[ADDR_W-1:0]),
        .wdata     (rt_i),
        .dm_ack    (dm_ack_i),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign  (is_misaligned(ALU_i[1:0])),
        .trap_pulse(misalign_o),
`endif
        .dm_req    (dm_req_o),
        .dm_we     (dm_we_o),
        .dm_addr   (dm_addr_o),
        .dm_wdata  (dm_wdata_o),
        .stall     (stall_o),
        .load_en   (load_en),
        .state_dbg (state_dbg)
    );

    // load_en is only raised for an access on its ack cycle, so is_load there
    // means the read data is valid on dm_rdata_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else if (load_en) begin
            wb_q.RegWrite <= RegWrite_i;
            wb_q.MemtoReg <= MemtoReg_i;
            wb_q.ALU      <= ALU_i;
            wb_q.rd       <= rd_i;
            if (is_load) wb_q.MEM <= dm_rdata_i;
        end else begin
            wb_q.RegWrite <= 1'b0;
            wb_q.MemtoReg <= 1'b0;
        end
    end

    assign RegWrite_o = wb_q.RegWrite;
    assign MemtoReg_o = wb_q.MemtoReg;
    assign ALU_o      = wb_q.ALU;
    assign MEM_o      = wb_q.MEM;
    assign rd_o       = wb_q.rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: random lw/sw/ALU stream against a
// word-addressed memory model, plus directed latency and reset cases.
module tb_mem_wb_stage;
    import pipe_pkg::*;

    logic        clk, rst_n;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALU_i, rt_i;
    logic [4:0]  rd_i;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        stall_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALU_o, MEM_o;
    logic [4:0]  rd_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALU_i(ALU_i), .rt_i(rt_i), .rd_i(rd_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
        .stall_o(stall_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALU_o(ALU_o), .MEM_o(MEM_o), .rd_o(rd_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // Expected WB bundle: {misalign, RegWrite, MemtoReg, ALU, MEM, rd}
    logic [71:0] exp_q[$];
    logic [7:0]  stall_q[$];
    logic [64:0] req_q[$];   // {we, addr, wdata}
    logic [7:0]  wait_q[$];

    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];
    logic [31:0] m_alu, m_mem;
    logic [4:0]  m_rd;

    logic        mon_en = 1'b0;
    logic        resp_en = 1'b0;
    logic        stall_s = 1'b0;
    logic [71:0] mon_last;
    int          stall_cnt = 0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return ref_mem.exists(k) ? ref_mem[k] : mem_init(k);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return dev_mem.exists(k) ? dev_mem[k] : mem_init(k);
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic zero_inputs();
        RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
        ALU_i = 0; rt_i = 0; rd_i = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        zero_inputs();
        dm_ack_i = 0; dm_rdata_i = 0;
        m_alu = 0; m_mem = 0; m_rd = 0;
        mon_last = '0; stall_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    // Presents one EX/MEM instruction and holds it until the DUT stops stalling.
    task automatic do_instr(input logic rw, input logic mtr, input logic mr, input logic mw,
                            input logic [31:0] alu, input logic [31:0] rt,
                            input logic [4:0] rd, input int wcyc);
        logic acc, misal;
        int n;
        RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
        ALU_i = alu; rt_i = rt; rd_i = rd;
        acc = mr | mw;
        misal = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misal = acc && (alu[1:0] != 2'b00);
`endif
        if (misal) begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, m_alu, m_mem, m_rd});
            stall_q.push_back(8'd0);
        end else begin
            if (acc) begin
                req_q.push_back({mw, alu, rt});
                wait_q.push_back(8'(wcyc));
                stall_q.push_back(8'(1 + wcyc));
                if (mw) ref_mem[{alu[31:2], 2'b00}] = rt;
                else    m_mem = ref_rd(alu);
            end else begin
                stall_q.push_back(8'd0);
            end
            m_alu = alu; m_rd = rd;
            exp_q.push_back({1'b0, rw, mtr, alu, m_mem, rd});
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o && n < 100);
        if (n >= 100) begin
            check("stall_timeout", 160'(stall_o), 160'(0));
            report();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    initial begin
        logic [64:0] r;
        int w;
        dm_ack_i = 0;
        dm_rdata_i = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && dm_req_o) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 160'(dm_req_o), 160'(0));
                    r = {dm_we_o, dm_addr_o, dm_wdata_o};
                    w = 0;
                end else begin
                    r = req_q.pop_front();
                    w = int'(wait_q.pop_front());
                    check("req_fields", 160'({dm_we_o, dm_addr_o, dm_wdata_o}), 160'(r));
                end
                repeat (w) begin
                    @(posedge clk);
                    #1;
                    check("req_hold", 160'({dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o}),
                          160'({1'b1, r}));
                end
                if (dm_we_o) begin
                    dev_mem[{dm_addr_o[31:2], 2'b00}] = dm_wdata_o;
                    dm_rdata_i = $urandom;
                end else begin
                    dm_rdata_i = dev_rd(dm_addr_o);
                end
                dm_ack_i = 1'b1;
                @(posedge clk);
                #1;
                dm_ack_i = 1'b0;
                dm_rdata_i = $urandom;
                check("req_drop", 160'(dm_req_o), 160'(0));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) stall_s = stall_o;

    initial begin
        logic en, st;
        logic [71:0] e;
        forever begin
            @(posedge clk);
            en = mon_en;
            st = stall_s;
            #2;
            if (en) begin
                if (st) begin
                    stall_cnt++;
                    check("bubble", 160'({RegWrite_o, MemtoReg_o, ALU_o, MEM_o, rd_o}),
                          160'({2'b00, mon_last[68:0]}));
`ifdef MEM_MISALIGN_TRAP_EN
                    check("misalign_idle", 160'(misalign_o), 160'(0));
`endif
                end else if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 160'(exp_q.size()), 160'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("wb_bundle", 160'({RegWrite_o, MemtoReg_o, ALU_o, MEM_o, rd_o}),
                          160'(e[70:0]));
`ifdef MEM_MISALIGN_TRAP_EN
                    check("misalign_pulse", 160'(misalign_o), 160'(e[71]));
`endif
                    check("stall_cycles", 160'(stall_cnt), 160'(stall_q.pop_front()));
                    stall_cnt = 0;
                    mon_last = e;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        check("watchdog", 160'(0), 160'(1));
        report();
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        int kind;
        apply_reset();
        check("reset_state", {dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, stall_o,
                              RegWrite_o, MemtoReg_o, ALU_o, MEM_o, rd_o}, 160'(0));

        ref_mem[32'h100] = 32'hDEADBEEF;
        dev_mem[32'h100] = 32'hDEADBEEF;
        mon_en = 1'b1;
        resp_en = 1'b1;

        // directed: R-type, lw zero-wait, sw three waits, back-to-back loads
        do_instr(1, 0, 0, 0, 32'h15, 32'h0, 5'd5, 0);
        do_instr(1, 1, 1, 0, 32'h100, 32'h0, 5'd8, 0);
        do_instr(0, 0, 0, 1, 32'h200, 32'hCAFE0001, 5'd0, 3);
        do_instr(1, 1, 1, 0, 32'h200, 32'h0, 5'd9, 1);
        do_instr(1, 1, 1, 0, 32'h100, 32'h0, 5'd10, 0);
        do_instr(1, 1, 1, 1, 32'h104, 32'h12345678, 5'd11, 2);
        do_instr(1, 1, 1, 0, 32'h104, 32'h0, 5'd12, 0);

        // random stream
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 4);
            a = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            case (kind)
                0, 1: do_instr(1'($urandom), 1'($urandom), 0, 0, $urandom, $urandom,
                               5'($urandom), 0);
                2:    do_instr(1, 1, 1, 0, a, $urandom, 5'($urandom),
                               $urandom_range(0, 4));
                3:    do_instr(1'($urandom), 0, 0, 1, a, $urandom, 5'($urandom),
                               $urandom_range(0, 4));
                default: do_instr(1'($urandom), 1'($urandom), 1, 1, a, $urandom,
                                  5'($urandom), $urandom_range(0, 4));
            endcase
        end
        zero_inputs();
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("exp_q_drained", 160'(exp_q.size()), 160'(0));
        check("req_q_drained", 160'(req_q.size()), 160'(0));

        // reset while an access is outstanding; the late ack must be ignored
        resp_en = 1'b0;
        RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; ALU_i = 32'h300; rd_i = 5'd7;
        @(posedge clk);
        #1;
        check("midreset_issue", 160'(dm_req_o), 160'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        check("midreset_async", {dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, stall_o,
                                 RegWrite_o, MemtoReg_o, ALU_o, MEM_o, rd_o}, 160'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        dm_ack_i = 1'b0;
        check("late_ack_ignored", {dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, stall_o,
                                   RegWrite_o, MemtoReg_o, ALU_o, MEM_o, rd_o}, 160'(0));
        check("late_ack_state", 160'(dut.u_fsm.state_dbg), 160'(IDLE));

        report();
    end

endmodule
